// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and
// the status characters the requesters commonly send.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_F = 8'h46;
  localparam logic [7:0] ASCII_E = 8'h45;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester set after
// 'last', wrapping modulo N. Produces a one-hot grant and its index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;
  logic          found;

  // NOTE: every signal driven here gets a default first, so no path can hold
  // an old value and infer a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, last} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      pos = sum[IW-1:0];
      if (en && !found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among NREQ byte sources, with an
// abort when the transmitter fails to assert busy after a send.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int START_TO = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_send,
  input  logic                    tx_busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    active,
  output logic                    start_err
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(START_TO);
  localparam logic [TW-1:0] TIMER_LAST = TW'(START_TO - 1);

  state_t        state, state_next;
  logic [IW-1:0] last, last_next;
  logic [TW-1:0] timer, timer_next;
  logic [7:0]    data_next;
  logic [IW-1:0] id_next;
  logic [NREQ-1:0] ready_next;
  logic          send_next, err_next;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req  (req_valid),
    .last (last),
    .en   ((state == IDLE) && !tx_busy),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  always_comb begin
    state_next = state;
    last_next  = last;
    timer_next = timer;
    data_next  = tx_data;
    id_next    = grant_id;
    ready_next = '0;
    send_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (|gnt) begin
          ready_next = gnt;
          data_next  = req_data[{gnt_idx, 3'b000} +: 8];
          id_next    = gnt_idx;
          last_next  = gnt_idx;
          state_next = SEND;
        end
      end
      SEND: begin
        send_next  = 1'b1;
        timer_next = '0;
        state_next = WAIT_START;
      end
      WAIT_START: begin
        // Leaving at TIMER_LAST keeps the timer from ever wrapping.
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timer == TIMER_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= IW'(NREQ - 1);
      timer     <= '0;
      tx_data   <= '0;
      grant_id  <= '0;
      req_ready <= '0;
      tx_send   <= 1'b0;
      start_err <= 1'b0;
    end else begin
      state     <= state_next;
      last      <= last_next;
      timer     <= timer_next;
      tx_data   <= data_next;
      grant_id  <= id_next;
      req_ready <= ready_next;
      tx_send   <= send_next;
      start_err <= err_next;
    end
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched with a simple uart_tx busy
// model; inputs driven and outputs sampled on the falling clock edge.
module tb_uart_tx_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        start_err;

  logic busy_model;
  logic busy_force;
  logic model_en;
  int   busy_len;

  int checks;
  int errors;

  assign tx_busy = busy_model | busy_force;

  uart_tx_sched #(.NREQ(4), .START_TO(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active),
    .start_err (start_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // uart_tx stand-in: busy rises one cycle after a send, stays high busy_len cycles.
  initial begin
    busy_model = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (model_en && tx_send) begin
        @(posedge clk);
        #2 busy_model = 1'b1;
        repeat (busy_len) @(posedge clk);
        #2 busy_model = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (req_ready == 4'b0 && cyc < 200);
  endtask

  task automatic wait_idle(output int sends, output logic [3:0] readies);
    int cyc;
    cyc     = 0;
    sends   = 0;
    readies = '0;
    while (active && cyc < 300) begin
      tick();
      cyc++;
      if (tx_send) sends++;
      readies |= req_ready;
    end
  endtask

  initial begin
    int         cyc;
    int         sends;
    logic [3:0] readies;
    int         exp_id;

    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    busy_force = 1'b0;
    model_en   = 1'b1;
    busy_len   = 5;

    // Reset state
    tick();
    check("rst_ready", req_ready, 4'b0000);
    check("rst_send", tx_send, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_err", start_err, 1'b0);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_tx_data", tx_data, 8'h00);
    tick();
    reset = 1'b1;
    tick();

    // All four valid and held: strict rotation 0,1,2,3,0 with pointer wrap
    req_data  = 32'h44434241;
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_id = g % 4;
      wait_ready(cyc);
      check($sformatf("rot%0d_ready", g), req_ready, 32'(1) << exp_id);
      check($sformatf("rot%0d_data", g), tx_data, 32'h41 + exp_id);
      check($sformatf("rot%0d_id", g), grant_id, exp_id);
    end

    // Reset asserted mid-WAIT_DONE: outputs clear at once, requester 0 wins after
    cyc = 0;
    while (!tx_busy && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    check("mid_active_pre", active, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_active", active, 1'b0);
    check("mid_rst_ready", req_ready, 4'b0000);
    check("mid_rst_data", tx_data, 8'h00);
    check("mid_rst_id", grant_id, 2'd0);
    cyc = 0;
    while (tx_busy && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_ready", req_ready, 4'b0001);
    req_valid = '0;
    wait_idle(sends, readies);
    check("post_rst_idle", active, 1'b0);

    // Single requester 2 sending 'F' with a 100-cycle frame
    busy_len  = 100;
    tick();
    req_data  = 32'h00460000;
    req_valid = 4'b0100;
    tick();
    check("s2_ready", req_ready, 4'b0100);
    check("s2_data", tx_data, 8'h46);
    check("s2_send_early", tx_send, 1'b0);
    check("s2_active", active, 1'b1);
    req_valid = '0;
    tick();
    check("s2_send", tx_send, 1'b1);
    check("s2_ready_gone", req_ready, 4'b0000);
    cyc   = 0;
    sends = 0;
    while (!tx_busy && cyc < 10) begin
      tick();
      cyc++;
      if (tx_send) sends++;
    end
    cyc = 0;
    while (tx_busy && cyc < 200) begin
      tick();
      cyc++;
      if (tx_send) sends++;
    end
    check("s2_busy_len", cyc, 100);
    check("s2_one_send", sends, 0);
    check("s2_active_tail", active, 1'b1);
    tick();
    check("s2_active_end", active, 1'b0);

    // Busy never rises: start_err 16 cycles after send, then rotation resumes
    busy_len  = 5;
    model_en  = 1'b0;
    req_data  = 32'h00004500;
    req_valid = 4'b0010;
    tick();
    check("to_ready", req_ready, 4'b0010);
    check("to_data", tx_data, 8'h45);
    req_valid = '0;
    tick();
    check("to_send", tx_send, 1'b1);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!start_err && cyc < 40);
    check("to_err_delay", cyc, 16);
    check("to_idle", active, 1'b0);
    tick();
    check("to_err_pulse", start_err, 1'b0);
    model_en  = 1'b1;
    req_data  = 32'h44434241;
    req_valid = 4'b1111;
    tick();
    check("to_next_ready", req_ready, 4'b0100);
    req_valid = '0;
    wait_idle(sends, readies);
    check("to_next_idle", active, 1'b0);

    // External busy blocks grants; grant follows one cycle after it drops
    tick();
    busy_force = 1'b1;
    req_valid  = 4'b0010;
    readies    = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      readies |= req_ready;
    end
    check("bz_no_ready", readies, 4'b0000);
    check("bz_idle", active, 1'b0);
    busy_force = 1'b0;
    tick();
    check("bz_ready", req_ready, 4'b0010);
    req_valid = '0;
    wait_idle(sends, readies);
    check("bz_idle_end", active, 1'b0);

    // Requester 3 withdraws on the cycle it would win: requester 0 granted
    tick();
    busy_force = 1'b1;
    req_valid  = 4'b1001;
    tick();
    tick();
    req_valid  = 4'b0001;
    busy_force = 1'b0;
    tick();
    check("wd_ready", req_ready, 4'b0001);
    check("wd_id", grant_id, 2'd0);
    check("wd_data", tx_data, 8'h41);
    req_valid = '0;
    wait_idle(sends, readies);
    check("wd_no_ready3", readies, 4'b0000);
    check("wd_idle", active, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
